// File: rtl/oled_refresh_ctrl_if.sv
// rtl/oled_refresh_ctrl_if.sv - frame-buffer read port and transmit byte stream of the refresh sequencer
interface oled_refresh_ctrl_if;
    logic       rden;
    logic [9:0] rdaddress;
    logic [7:0] q;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_dc;
    logic [7:0] tx_byte;

    modport master (
        output rden, rdaddress, tx_valid, tx_dc, tx_byte,
        input  q, tx_ready
    );

    modport slave (
        input  rden, rdaddress, tx_valid, tx_dc, tx_byte,
        output q, tx_ready
    );
endinterface

// File: rtl/oled_refresh_ctrl.sv
// rtl/oled_refresh_ctrl.sv - page-by-page OLED frame-buffer refresh sequencer
module oled_refresh_ctrl #(
    parameter bit         CONTINUOUS = 1'b1,
    parameter logic [7:0] COL_OFFSET = 8'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       wr_active,
    oled_refresh_ctrl_if.master        bus,
    output logic                       busy,
    output logic                       frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD, S_LAT, S_SEND, S_DONE} state_e;

    state_e     state_q, state_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    logic [1:0] cmd_idx_q, cmd_idx_d;
    logic       rden_q, rden_d;
    logic [9:0] rdaddress_q, rdaddress_d;
    logic       tx_valid_q, tx_valid_d;
    logic       tx_dc_q, tx_dc_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] pg);
        case (idx)
            2'd0:    return 8'hB0 | {5'd0, pg};
            2'd1:    return {4'h0, COL_OFFSET[3:0]};
            default: return {4'h1, COL_OFFSET[7:4]};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            page_q       <= 3'd0;
            col_q        <= 7'd0;
            cmd_idx_q    <= 2'd0;
            rden_q       <= 1'b0;
            rdaddress_q  <= 10'd0;
            tx_valid_q   <= 1'b0;
            tx_dc_q      <= 1'b0;
            tx_byte_q    <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            col_q        <= col_d;
            cmd_idx_q    <= cmd_idx_d;
            rden_q       <= rden_d;
            rdaddress_q  <= rdaddress_d;
            tx_valid_q   <= tx_valid_d;
            tx_dc_q      <= tx_dc_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Page p lives at (7-p)*128, so the page field of the address is simply ~p.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        col_d        = col_q;
        cmd_idx_d    = cmd_idx_q;
        rden_d       = 1'b0;
        rdaddress_d  = rdaddress_q;
        tx_valid_d   = tx_valid_q;
        tx_dc_d      = tx_dc_q;
        tx_byte_d    = tx_byte_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The frame_done cycle is held idle so back-to-back frames get one dead cycle.
                if (en && !wr_active && !frame_done_q) begin
                    state_d    = S_CMD;
                    page_d     = 3'd0;
                    col_d      = 7'd0;
                    cmd_idx_d  = 2'd0;
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_byte_d  = cmd_byte(2'd0, 3'd0);
                    busy_d     = 1'b1;
                end
            end
            S_CMD: begin
                if (bus.tx_ready) begin
                    if (cmd_idx_q != 2'd2) begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                        tx_byte_d = cmd_byte(cmd_idx_q + 2'd1, page_q);
                    end else begin
                        tx_valid_d  = 1'b0;
                        col_d       = 7'd0;
                        rden_d      = 1'b1;
                        rdaddress_d = {~page_q, 7'd0};
                        state_d     = S_RD;
                    end
                end
            end
            S_RD: state_d = S_LAT;
            S_LAT: begin
                tx_byte_d  = bus.q;
                tx_dc_d    = 1'b1;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (col_q != 7'd127) begin
                        col_d       = col_q + 7'd1;
                        rden_d      = 1'b1;
                        rdaddress_d = {~page_q, col_q + 7'd1};
                        state_d     = S_RD;
                    end else if (page_q != 3'd7) begin
                        page_d     = page_q + 3'd1;
                        cmd_idx_d  = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_dc_d    = 1'b0;
                        tx_byte_d  = cmd_byte(2'd0, page_q + 3'd1);
                        state_d    = S_CMD;
                    end else begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = CONTINUOUS ? S_IDLE : S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rden      = rden_q;
    assign bus.rdaddress = rdaddress_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_dc     = tx_dc_q;
    assign bus.tx_byte   = tx_byte_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
endmodule

// File: doc/oled_refresh_ctrl.md
# oled_refresh_ctrl

Frame-buffer refresh sequencer for the OLED display path. Scans the 1024-byte page-organised frame-buffer RAM (filled by the static text writer) page by page. For each page it emits the three page/column addressing command bytes, then the page's 128 data bytes, to the serial transport over a valid/ready byte handshake. Sits between the frame-buffer RAM read port and the SPI/I2C byte transmitter, and is enabled once the panel init sequence has finished.

## Interface
- `CONTINUOUS`, default 1: 1 = restart a new frame automatically while `en` stays high; 0 = one frame per rising `en`.
- `COL_OFFSET`, default 0: 8-bit start column sent in the column commands (2 for SH1106 panels).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: refresh enable (level), driven by init-done.
- `wr_active` in 1: frame-buffer writer busy; defers frame start only.
- `rden` out 1: RAM read enable, registered.
- `rdaddress` out 10: RAM read address, registered.
- `q` in 8: RAM read data, valid the cycle after `rden`.
- `tx_valid` out 1: byte available to transport.
- `tx_ready` in 1: transport accepts byte when high with `tx_valid`.
- `tx_dc` out 1: 0 = command byte, 1 = display data byte.
- `tx_byte` out 8: byte to send.
- `busy` out 1: high from frame start until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last data byte is accepted.

## Operation
- Address map: page p (0..7), column c (0..127) is at RAM address (7−p)*128 + c. Page 0 = 896..1023 and page 7 = 0..127.
- Page order is 0→7. Column order is 0→127.
- Commands per page, in order: 8'hB0|p, 8'h00|COL_OFFSET[3:0], 8'h10|COL_OFFSET[7:4]. All have `tx_dc`=0.
- States:
  - IDLE: if `en` && !`wr_active`, go to CMD, set page=0, assert `busy`.
  - CMD: present the command byte. On accept, advance cmd index 0→1→2. After index 2, go to RD with col=0.
  - RD: pulse `rden` one cycle with the current address. Go to LAT.
  - LAT: `q` valid. Capture it into `tx_byte`, set `tx_dc`=1. Go to SEND.
  - SEND: hold `tx_valid` until accepted. Then:
    - col<127: col+1, go to RD.
    - col==127, page<7: page+1, go to CMD.
    - col==127, page==7: pulse `frame_done`, drop `busy`, then go to IDLE if CONTINUOUS=1, else DONE.
  - DONE: wait for `en`=0, then go to IDLE.
- `en` falling mid-frame does not abort; the current frame completes. `wr_active` is sampled only in IDLE.
- Page and column counters never wrap inside a frame. Column is 7 bits, page is 3 bits. Address arithmetic is 10-bit with no overflow.

## Timing
- Reset values: `rden`=0, `rdaddress`=0, `tx_valid`=0, `tx_dc`=0, `tx_byte`=0, `busy`=0, `frame_done`=0. State=IDLE, page=0, col=0.
- Reset asserted mid-frame clears all of the above immediately. The next frame restarts at page 0 command 0.
- Frame start: when `en`=1 and `wr_active`=0 are sampled in IDLE at edge T, `tx_valid`=1 with `tx_byte`=8'hB0 and `busy`=1 from T+1.
- Handshake: `tx_byte` and `tx_dc` are stable while `tx_valid` && !`tx_ready`. A transfer completes on any edge with both high. `tx_valid` never depends combinationally on `tx_ready`.
- With `tx_ready`=1, the three command bytes go out on consecutive cycles.
- Data timing after an accept at edge T: `rden`=1 during T+1, `q` is captured at T+2, `tx_valid`=1 from T+3. This gives 3 cycles per data byte minimum.
- `tx_valid` is low between bytes.
- `frame_done` is high exactly the cycle after the final accept, coincident with `busy` falling.
- In CONTINUOUS=1 with `en` held, the next frame's first command is valid 2 cycles after `frame_done`.

## Test plan
- Reset, then `en`=1, `tx_ready`=1, RAM preloaded with data = addr[7:0] ^ addr[9:8] → stream of 8×(3+128)=1048 bytes, `tx_dc` pattern correct. Page 0 commands are B0,00,10, and its first data byte comes from address 896. `frame_done` pulses once.
- COL_OFFSET=2 → each page's commands are B0+p, 02, 10. Page 7 data is read from addresses 0..127.
- Random `tx_ready` backpressure (about 50% low) → byte sequence identical to the stalled-free run. `tx_byte`/`tx_dc` are never changed while `tx_valid` && !`tx_ready`.
- `wr_active`=1 when `en` rises → no `tx_valid` while it is high. Frame starts 1 cycle after it falls. Toggling `wr_active` mid-frame has no effect.
- CONTINUOUS=0: `en` high for 3 frames' worth of time → exactly one `frame_done`. Dropping `en` and raising it again → second frame.
- `rst_n` pulsed low mid-page 4 → all outputs return to reset values asynchronously. On re-enable, the first byte is B0 (page 0).
